// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER RISC-V MCU: fetch, execute, load write-back, interrupt entry.
// Define OTTER_INTR_LATCH_EN to latch interrupt requests until serviced (default: level-sensitive intr).
module otter_cu_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       intr,
    input  logic       mie,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       rst_out,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wb_cnt;
    logic             pend;
    logic             take_intr;

    assign state_o   = state;
    assign take_intr = pend && mie;

`ifdef OTTER_INTR_LATCH_EN
    // Clear wins over a same-cycle set so a request held through INTR is not re-taken.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend <= 1'b0;
        end else if (state == ST_INTR) begin
            pend <= 1'b0;
        end else if (intr) begin
            pend <= 1'b1;
        end
    end
`else
    assign pend = intr;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_INIT;
            wb_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == ST_EXEC && opcode == OP_LOAD) begin
                wb_cnt <= CNT_W'(MEM_WAIT);
            end else if (state == ST_WB && wb_cnt != '0) begin
                wb_cnt <= wb_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        PC_WE      = 1'b0;
        RF_WE      = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        memWE2     = 1'b0;
        csr_WE     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        rst_out    = 1'b0;
        case (state)
            ST_INIT: begin
                rst_out    = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = take_intr ? ST_INTR : ST_FETCH;
                PC_WE      = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        memRDEN2   = 1'b1;
                        PC_WE      = 1'b0;
                        next_state = ST_WB;
                    end
                    OP_STORE:  memWE2 = 1'b1;
                    OP_BRANCH: ;
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: RF_WE = 1'b1;
                    OP_SYS: begin
                        if (func3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else if (func3 == 3'b001 || func3 == 3'b010 || func3 == 3'b011) begin
                            RF_WE  = 1'b1;
                            csr_WE = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                memRDEN2 = 1'b1;
                // Interrupts are only considered once the load has retired.
                if (wb_cnt == '0) begin
                    RF_WE      = 1'b1;
                    PC_WE      = 1'b1;
                    next_state = take_intr ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                int_taken  = 1'b1;
                PC_WE      = 1'b1;
                next_state = ST_FETCH;
            end
            default: next_state = ST_INIT;
        endcase
    end

endmodule
